// File: rtl/exec_wb.sv
// rtl/exec_wb.sv - three-stage execute/write-back core (E0 issue, E1 wait, E2 retire)
// Loads read memory from E0 and pick up mem_rdata in E2; younger work behind an invalid op is squashed.
module exec_wb #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   input  logic [W-1:0] in_instr,
   input  logic [W-1:0] in_va,
   input  logic [W-1:0] in_vb,
   output logic         stall,
   output logic         redirect_valid,
   output logic [W-1:0] redirect_pc,
   output logic [W-2:0] mem_raddr,
   input  logic [W-1:0] mem_rdata,
   output logic         mem_wen,
   output logic [W-2:0] mem_waddr,
   output logic [W-1:0] mem_wdata,
   output logic         reg_wen,
   output logic [3:0]   reg_waddr,
   output logic [W-1:0] reg_wdata,
   output logic         out_valid,
   output logic [7:0]   out_char,
   output logic         halt
);

   localparam logic [2:0] K_SUB  = 3'd0;
   localparam logic [2:0] K_MOVL = 3'd1;
   localparam logic [2:0] K_MOVH = 3'd2;
   localparam logic [2:0] K_LD   = 3'd3;
   localparam logic [2:0] K_ST   = 3'd4;
   localparam logic [2:0] K_JMP  = 3'd5;
   localparam logic [2:0] K_BAD  = 3'd6;

   logic [3:0]   w_in_op, w_in_ra, w_in_rb, w_in_rt, w_in_srcb;
   logic [2:0]   w_in_kind;
   logic         w_use_a, w_use_b, w_accept, w_kill, w_taken;
   logic [W-1:0] w_fa, w_fb, w_e0_res, w_e2_res;
   logic         w_e0_wr, w_e1_wr, w_e2_wr, w_e1_bad, w_e2_bad, w_e2_wb;
   logic         w_hit_a, w_hit_b;

   logic         r_e0_v, r_e1_v, r_e2_v, r_halt;
   logic [2:0]   r_e0_kind, r_e1_kind, r_e2_kind;
   logic [3:0]   r_e0_rt, r_e1_rt, r_e2_rt;
   logic [1:0]   r_e0_cond;
   logic [7:0]   r_e0_imm;
   logic [W-1:0] r_e0_va, r_e0_vb, r_e1_res, r_e2_res;
   logic         r_rt_v;
   logic [3:0]   r_rt_addr;
   logic [W-1:0] r_rt_data;

   assign w_in_op = in_instr[15:12];
   assign w_in_ra = in_instr[11:8];
   assign w_in_rb = in_instr[7:4];
   assign w_in_rt = in_instr[3:0];

   always_comb begin
      w_in_kind = K_BAD;
      case (w_in_op)
         4'h0: w_in_kind = K_SUB;
         4'h8: w_in_kind = K_MOVL;
         4'h9: w_in_kind = K_MOVH;
         4'hE: if (w_in_rb < 4'd4) w_in_kind = K_JMP;
         4'hF: begin
            if (w_in_rb == 4'd0) w_in_kind = K_LD;
            else if (w_in_rb == 4'd1) w_in_kind = K_ST;
         end
         default: w_in_kind = K_BAD;
      endcase
   end

   assign w_in_srcb = (w_in_kind == K_SUB) ? w_in_rb : w_in_rt;
   assign w_use_a   = w_in_kind inside {K_SUB, K_LD, K_ST, K_JMP};
   assign w_use_b   = w_in_kind inside {K_SUB, K_MOVH, K_ST, K_JMP};

   assign w_e0_wr = r_e0_v && (r_e0_kind inside {K_SUB, K_MOVL, K_MOVH, K_LD}) && r_e0_rt != 4'd0;
   assign w_e1_wr = r_e1_v && (r_e1_kind inside {K_SUB, K_MOVL, K_MOVH, K_LD}) && r_e1_rt != 4'd0;
   assign w_e2_wr = r_e2_v && (r_e2_kind inside {K_SUB, K_MOVL, K_MOVH, K_LD}) && r_e2_rt != 4'd0;
   assign w_e1_bad = r_e1_v && r_e1_kind == K_BAD;
   assign w_e2_bad = r_e2_v && r_e2_kind == K_BAD;
   assign w_kill   = r_halt || w_e1_bad || w_e2_bad;

   always_comb begin
      w_e0_res = '0;
      case (r_e0_kind)
         K_SUB:  w_e0_res = r_e0_va - r_e0_vb;
         K_MOVL: w_e0_res = {{(W-8){r_e0_imm[7]}}, r_e0_imm};
         K_MOVH: w_e0_res = {{(W-8){1'b0}}, r_e0_vb[7:0]} | {r_e0_imm, {(W-8){1'b0}}};
         default: w_e0_res = '0;
      endcase
   end

   assign w_e2_res = (r_e2_kind == K_LD) ? mem_rdata : r_e2_res;

   // youngest producer wins; loads in E0/E1 have no value yet and are covered by stall
   assign w_fa = (w_e0_wr && r_e0_rt == w_in_ra) ? w_e0_res :
                 (w_e1_wr && r_e1_rt == w_in_ra) ? r_e1_res :
                 (w_e2_wr && r_e2_rt == w_in_ra) ? w_e2_res :
                 (r_rt_v && r_rt_addr == w_in_ra) ? r_rt_data : in_va;
   assign w_fb = (w_e0_wr && r_e0_rt == w_in_srcb) ? w_e0_res :
                 (w_e1_wr && r_e1_rt == w_in_srcb) ? r_e1_res :
                 (w_e2_wr && r_e2_rt == w_in_srcb) ? w_e2_res :
                 (r_rt_v && r_rt_addr == w_in_srcb) ? r_rt_data : in_vb;

   assign w_hit_a = (w_e0_wr && r_e0_kind == K_LD && r_e0_rt == w_in_ra) ||
                    (w_e1_wr && r_e1_kind == K_LD && r_e1_rt == w_in_ra);
   assign w_hit_b = (w_e0_wr && r_e0_kind == K_LD && r_e0_rt == w_in_srcb) ||
                    (w_e1_wr && r_e1_kind == K_LD && r_e1_rt == w_in_srcb);
   assign stall   = in_valid && ((w_use_a && w_hit_a) || (w_use_b && w_hit_b));

   always_comb begin
      case (r_e0_cond)
         2'd0:    w_taken = (r_e0_va == '0);
         2'd1:    w_taken = (r_e0_va != '0);
         2'd2:    w_taken = r_e0_va[W-1];
         default: w_taken = !r_e0_va[W-1];
      endcase
   end

   assign redirect_valid = r_e0_v && r_e0_kind == K_JMP && w_taken && !w_kill;
   assign redirect_pc    = redirect_valid ? r_e0_vb : '0;
   assign mem_raddr      = (r_e0_v && r_e0_kind == K_LD && !w_kill) ? r_e0_va[W-1:1] : '0;
   assign mem_wen        = r_e0_v && r_e0_kind == K_ST && !w_kill;
   assign mem_waddr      = mem_wen ? r_e0_va[W-1:1] : '0;
   assign mem_wdata      = mem_wen ? r_e0_vb : '0;

   assign w_e2_wb   = r_e2_v && (r_e2_kind inside {K_SUB, K_MOVL, K_MOVH, K_LD}) && !r_halt;
   assign reg_wen   = w_e2_wb && r_e2_rt != 4'd0;
   assign reg_waddr = reg_wen ? r_e2_rt : 4'd0;
   assign reg_wdata = reg_wen ? w_e2_res : '0;
   assign out_valid = w_e2_wb && r_e2_rt == 4'd0;
   assign out_char  = out_valid ? w_e2_res[7:0] : 8'd0;
   assign halt      = r_halt || w_e2_bad;

   assign w_accept = in_valid && !stall && !redirect_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_e0_v    <= 1'b0;
         r_e1_v    <= 1'b0;
         r_e2_v    <= 1'b0;
         r_halt    <= 1'b0;
         r_rt_v    <= 1'b0;
         r_rt_addr <= 4'd0;
         r_rt_data <= '0;
      end else begin
         r_e0_v    <= w_accept;
         r_e1_v    <= r_e0_v;
         r_e2_v    <= r_e1_v;
         r_halt    <= r_halt || w_e2_bad;
         r_rt_v    <= reg_wen;
         r_rt_addr <= reg_waddr;
         r_rt_data <= reg_wdata;
      end
   end

   always_ff @(posedge clk) begin
      r_e0_kind <= w_in_kind;
      r_e0_rt   <= w_in_rt;
      r_e0_cond <= w_in_rb[1:0];
      r_e0_imm  <= in_instr[11:4];
      r_e0_va   <= w_fa;
      r_e0_vb   <= w_fb;
      r_e1_kind <= r_e0_kind;
      r_e1_rt   <= r_e0_rt;
      r_e1_res  <= w_e0_res;
      r_e2_kind <= r_e1_kind;
      r_e2_rt   <= r_e1_rt;
      r_e2_res  <= r_e1_res;
   end

endmodule

// File: tb/tb_exec_wb.sv
// tb/tb_exec_wb.sv - directed self-checking bench for exec_wb
module tb_exec_wb;

   logic        clk = 1'b0;
   logic        reset, in_valid;
   logic [15:0] in_instr, in_va, in_vb, mem_rdata;
   logic        stall, redirect_valid, mem_wen, reg_wen, out_valid, halt;
   logic [15:0] redirect_pc, mem_wdata, reg_wdata;
   logic [14:0] mem_raddr, mem_waddr;
   logic [3:0]  reg_waddr;
   logic [7:0]  out_char;

   int checks = 0;
   int errors = 0;
   int n_reg_wen = 0, n_out = 0, n_mem_wen = 0;
   int snap_reg, snap_out, snap_mem;

   always #5 clk = ~clk;

   exec_wb #(.W(16)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
      .in_va(in_va), .in_vb(in_vb), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
      .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
      .out_valid(out_valid), .out_char(out_char), .halt(halt)
   );

   always @(negedge clk) begin
      if (reg_wen) n_reg_wen++;
      if (out_valid) n_out++;
      if (mem_wen) n_mem_wen++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] i, input logic [15:0] a, input logic [15:0] b);
      in_valid = v;
      in_instr = i;
      in_va    = a;
      in_vb    = b;
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      reset = 1'b1;
      mem_rdata = 16'h0;
      drive(1'b0, 16'h0, 16'h0, 16'h0);
      tick();
      tick();
      check("rst_stall", stall, 0);
      check("rst_halt", halt, 0);
      check("rst_reg_wen", reg_wen, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_redirect", redirect_valid, 0);
      check("rst_mem_wen", mem_wen, 0);
      reset = 1'b0;

      // movl r1,0x41 ; sub r0 = r1 - r2
      drive(1'b1, 16'h8411, 16'h0, 16'h0);
      tick();
      drive(1'b1, 16'h0120, 16'h0, 16'h0);
      check("s1_stall", stall, 0);
      tick();
      drive(1'b0, 16'h0, 16'h0, 16'h0);
      tick();
      check("s1_r1_wen", reg_wen, 1);
      check("s1_r1_addr", reg_waddr, 1);
      check("s1_r1_data", reg_wdata, 16'h0041);
      tick();
      check("s1_out_valid", out_valid, 1);
      check("s1_out_char", out_char, 8'h41);
      check("s1_r0_no_wen", reg_wen, 0);
      tick();
      check("s1_out_once", n_out, 1);
      check("s1_out_low", out_valid, 0);

      // movl r3,5 ; sub r4 = r3 - r3 with stale operands
      drive(1'b1, 16'h8053, 16'h0, 16'h0);
      tick();
      drive(1'b1, 16'h0334, 16'hDEAD, 16'h0001);
      check("s2_stall", stall, 0);
      tick();
      drive(1'b0, 16'h0, 16'h0, 16'h0);
      tick();
      check("s2_r3_addr", reg_waddr, 3);
      check("s2_r3_data", reg_wdata, 16'h0005);
      tick();
      check("s2_r4_wen", reg_wen, 1);
      check("s2_r4_addr", reg_waddr, 4);
      check("s2_r4_data", reg_wdata, 16'h0000);

      // movl r8,0xFF (sign-extends) ; movh r8,0x12 keeps low byte
      tick();
      drive(1'b1, 16'h8FF8, 16'h0, 16'h0);
      tick();
      drive(1'b1, 16'h9128, 16'h0, 16'h3456);
      tick();
      drive(1'b0, 16'h0, 16'h0, 16'h0);
      tick();
      check("s2b_movl_data", reg_wdata, 16'hFFFF);
      tick();
      check("s2b_movh_addr", reg_waddr, 8);
      check("s2b_movh_data", reg_wdata, 16'h12FF);

      // ld r5,[r6] ; sub r7 = r5 - r5 stalls two cycles
      tick();
      drive(1'b1, 16'hF605, 16'h0100, 16'h0);
      tick();
      check("s3_raddr", mem_raddr, 15'h0080);
      drive(1'b1, 16'h0557, 16'h1111, 16'h2222);
      check("s3_stall_1", stall, 1);
      tick();
      check("s3_stall_2", stall, 1);
      tick();
      mem_rdata = 16'h1234;
      #1;
      check("s3_stall_off", stall, 0);
      check("s3_ld_wen", reg_wen, 1);
      check("s3_ld_addr", reg_waddr, 5);
      check("s3_ld_data", reg_wdata, 16'h1234);
      tick();
      mem_rdata = 16'h0;
      drive(1'b0, 16'h0, 16'h0, 16'h0);
      tick();
      tick();
      check("s3_sub_addr", reg_waddr, 7);
      check("s3_sub_data", reg_wdata, 16'h0000);

      // st [r2] <- r9
      tick();
      drive(1'b1, 16'hF219, 16'h0100, 16'hCAFE);
      tick();
      drive(1'b0, 16'h0, 16'h0, 16'h0);
      check("st_wen", mem_wen, 1);
      check("st_waddr", mem_waddr, 15'h0080);
      check("st_wdata", mem_wdata, 16'hCAFE);
      tick();
      check("st_wen_pulse", mem_wen, 0);

      // jz taken drops the next input; jnz with va=0 is not taken
      tick();
      tick();
      drive(1'b1, 16'hE209, 16'h0000, 16'h0020);
      tick();
      check("s4_redirect", redirect_valid, 1);
      check("s4_redirect_pc", redirect_pc, 16'h0020);
      snap_reg = n_reg_wen;
      drive(1'b1, 16'h877A, 16'h0, 16'h0);
      tick();
      check("s4_redirect_pulse", redirect_valid, 0);
      drive(1'b1, 16'hE219, 16'h0000, 16'h0040);
      tick();
      check("s4_jnz_not_taken", redirect_valid, 0);
      drive(1'b0, 16'h0, 16'h0, 16'h0);
      tick();
      tick();
      tick();
      check("s4_dropped_no_wen", n_reg_wen, snap_reg);

      // invalid opcode halts three cycles after accept and squashes a trailing store
      snap_mem = n_mem_wen;
      snap_reg = n_reg_wen;
      drive(1'b1, 16'h2000, 16'h0, 16'h0);
      tick();
      check("s5_halt_c1", halt, 0);
      drive(1'b1, 16'hF112, 16'h0010, 16'hBEEF);
      tick();
      check("s5_halt_c2", halt, 0);
      check("s5_st_blocked", mem_wen, 0);
      drive(1'b1, 16'h8011, 16'h0, 16'h0);
      tick();
      check("s5_halt_c3", halt, 1);
      drive(1'b0, 16'h0, 16'h0, 16'h0);
      tick();
      tick();
      tick();
      check("s5_halt_sticky", halt, 1);
      check("s5_no_mem_wen", n_mem_wen, snap_mem);
      check("s5_no_reg_wen", n_reg_wen, snap_reg);

      // reset clears halt, then reset with instructions in flight
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("s6_halt_cleared", halt, 0);
      drive(1'b1, 16'h8011, 16'h0, 16'h0);
      tick();
      drive(1'b1, 16'h8020, 16'h0, 16'h0);
      tick();
      snap_reg = n_reg_wen;
      snap_out = n_out;
      reset = 1'b1;
      drive(1'b1, 16'h8033, 16'h0, 16'h0);
      tick();
      reset = 1'b0;
      drive(1'b0, 16'h0, 16'h0, 16'h0);
      check("s6_reg_wen", reg_wen, 0);
      check("s6_out_valid", out_valid, 0);
      check("s6_halt", halt, 0);
      tick();
      tick();
      tick();
      tick();
      check("s6_no_reg_wen", n_reg_wen, snap_reg);
      check("s6_no_out", n_out, snap_out);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
